// File: rtl/dsp_arb_pkg.sv
// Shared types for the DSP slice arbiter: FSM state, tag-pipeline entry,
// and the index-width helper. Optional feature macro: DSP_ARB_FIXED_PRIO_EN.
package dsp_arb_pkg;

  // Owner field is sized for the largest supported requester count (8).
  localparam int OWNER_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
    logic               last;
  } tag_t;

  // Ceiling log2 with a floor of 1 so a 2-requester index is still 1 bit wide.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dsp_arb_rr_pick.sv
// Combinational masked round-robin picker: lowest requester at or above ptr,
// wrapping to the lowest overall. With DSP_ARB_FIXED_PRIO_EN defined the
// pick is plain fixed priority (lowest index) and ptr is ignored.
module dsp_arb_rr_pick
  import dsp_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] cand;

`ifdef DSP_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign cand = req;
`else
  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] masked;

  // Keep only requesters at or above the pointer; fall back to all when none.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NREQ; i++) mask[i] = (i >= int'(ptr));
  end

  assign masked = req & mask;
  assign cand   = (|masked) ? masked : req;
`endif

  // Lowest set bit of the candidate vector wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/dsp_share_arbiter.sv
// Shares one multiply-accumulate slice between NREQ requesters. Round-robin
// pick in IDLE, lock to the owner for a multi-beat accumulate burst, and a
// tag pipeline that routes each burst's final product back to its owner.
// Optional feature macro: DSP_ARB_FIXED_PRIO_EN (fixed-priority IDLE pick).
module dsp_share_arbiter
  import dsp_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH_A = 18,
  parameter int WIDTH_B = 18,
  parameter int WIDTH_P = 48,
  parameter int LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH_A-1:0]   req_a,
  input  logic [NREQ*WIDTH_B-1:0]   req_b,
  input  logic [NREQ-1:0]           req_last,
  output logic                      dsp_issue,
  output logic [WIDTH_A-1:0]        dsp_a,
  output logic [WIDTH_B-1:0]        dsp_b,
  output logic                      dsp_accum,
  input  logic [WIDTH_P-1:0]        dsp_p,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [WIDTH_P-1:0]        rsp_data,
  output logic                      busy
);

  localparam int IW = clog2(NREQ);

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] ready;
  logic            accept;
  logic [IW-1:0]   acc_idx;
  logic            acc_last;
  logic [WIDTH_A-1:0] acc_a;
  logic [WIDTH_B-1:0] acc_b;
  // Stage 0 rides alongside dsp_issue; stage LATENCY lines up with valid dsp_p.
  tag_t            tag_q [LATENCY+1];
  tag_t            tail;
  logic [IW-1:0]   tail_owner;
  logic            tag_any;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  dsp_arb_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Ready goes to the picked requester in IDLE, only to the owner in BURST.
  always_comb begin
    ready   = '0;
    acc_idx = pick_idx;
    if (state == ST_IDLE) begin
      ready = pick_grant;
    end else begin
      ready[owner] = req_valid[owner];
      acc_idx      = owner;
    end
  end

  assign req_ready = ready;
  assign accept    = |ready;
  assign acc_last  = req_last[acc_idx];
  assign acc_a     = req_a[int'(acc_idx)*WIDTH_A +: WIDTH_A];
  assign acc_b     = req_b[int'(acc_idx)*WIDTH_B +: WIDTH_B];

  // Burst lock FSM and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= '0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        owner <= pick_idx;
        if (!acc_last) state <= ST_BURST;
`ifndef DSP_ARB_FIXED_PRIO_EN
        else ptr <= next_idx(pick_idx);
`endif
      end else if (acc_last) begin
        state <= ST_IDLE;
`ifndef DSP_ARB_FIXED_PRIO_EN
        ptr <= next_idx(owner);
`endif
      end
    end
  end

  // Operand registers toward the slice; the first beat of a burst restarts P.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_issue <= 1'b0;
      dsp_a     <= '0;
      dsp_b     <= '0;
      dsp_accum <= 1'b0;
    end else begin
      dsp_issue <= accept;
      if (accept) begin
        dsp_a     <= acc_a;
        dsp_b     <= acc_b;
        dsp_accum <= (state == ST_BURST);
      end
    end
  end

  // Tag shift register tracking in-flight beats through the slice latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{valid: accept, owner: OWNER_W'(acc_idx), last: accept & acc_last};
      for (int k = 1; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tail       = tag_q[LATENCY];
  assign tail_owner = IW'(tail.owner);

  // Capture the final accumulated product and strobe its owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (tail.valid && tail.last) begin
        rsp_valid[tail_owner] <= 1'b1;
        rsp_data              <= dsp_p;
      end
    end
  end

  // Any beat still travelling through the slice.
  always_comb begin
    tag_any = 1'b0;
    for (int k = 0; k <= LATENCY; k++) tag_any = tag_any | tag_q[k].valid;
  end

  assign busy = (state == ST_BURST) | tag_any;

endmodule
